// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bus bundle between the fetch stage and its surroundings
//                (program start handshake, instruction ROM, branch LUT and
//                decode-side instruction register).
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_if #(
    parameter int PCW = 10,
    parameter int IW  = 9
);
    logic           Start;
    logic [PCW-1:0] start_pc;
    logic [PCW-1:0] rom_addr;
    logic [IW-1:0]  rom_data;
    logic [IW-1:0]  instr;
    logic [PCW-1:0] instr_pc;
    logic           jump_en;
    logic           br_lut_sel;
    logic [3:0]     lut_idx;
    logic [PCW-1:0] lut_target;
    logic           Done;

    // Fetch-stage side
    modport master (
        input  Start, start_pc, rom_data, jump_en, br_lut_sel, lut_target,
        output rom_addr, instr, instr_pc, lut_idx, Done
    );

    // Environment side (ROM, LUT, Control, program sequencer)
    modport slave (
        output Start, start_pc, rom_data, jump_en, br_lut_sel, lut_target,
        input  rom_addr, instr, instr_pc, lut_idx, Done
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Program counter and instruction register stage. Addresses
//                the asynchronous instruction ROM, registers the fetched word,
//                applies taken branches (relative or LUT target) with a single
//                NOP bubble, and wraps each program in a Start/Done handshake.
//                Optional build macro FETCH_PERF_EN adds saturating run-cycle
//                and taken-branch counters (cycle_cnt, taken_cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter int            PCW        = 10,
    parameter int            IW         = 9,
    parameter logic [IW-1:0] HALT_INSTR = 9'h00F
) (
    input  logic              Clk,
    input  logic              Reset,
    instr_fetch_if.master     bus
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       cycle_cnt,
    output logic [15:0]       taken_cnt
`endif
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [PCW-1:0] pc_q,    pc_d;
    logic [IW-1:0]  ir_q,    ir_d;
    logic [PCW-1:0] ipc_q,   ipc_d;

    logic           w_start;
    logic           w_run;
    logic           w_halt;
    logic           w_ir_nop;
    logic           w_take_br;
    logic [PCW-1:0] w_rel_target;
    logic [PCW-1:0] w_br_target;

    // Start is only honoured while idle or finished; a NOP-opcode word never
    // carries a branch, which also covers the flushed bubble and HALT_INSTR.
    assign w_start      = bus.Start && ((state_q == c_IDLE) || (state_q == c_DONE));
    assign w_run        = (state_q == c_RUN);
    assign w_halt       = w_run && (ir_q == HALT_INSTR);
    assign w_ir_nop     = (ir_q[IW-1:IW-5] == '0);
    assign w_take_br    = w_run && bus.jump_en && !w_ir_nop;
    // Offset is relative to the branch's own address, wraps mod 2^PCW.
    assign w_rel_target = ipc_q + {{(PCW-4){ir_q[3]}}, ir_q[3:0]};
    assign w_br_target  = bus.br_lut_sel ? bus.lut_target : w_rel_target;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_start) state_d = c_RUN;
            c_RUN:   if (w_halt)  state_d = c_DONE;
            c_DONE:  if (w_start) state_d = c_RUN;
            default: state_d = c_IDLE;
        endcase
    end

    // Outputs decoded from state and datapath registers
    always_comb begin
        bus.Done     = (state_q == c_DONE);
        bus.rom_addr = pc_q;
        bus.instr    = ir_q;
        bus.instr_pc = ipc_q;
        bus.lut_idx  = ir_q[3:0];
    end

    // Datapath next values: load on start, fetch or redirect while running
    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        ipc_d = ipc_q;
        if (w_start) begin
            pc_d = bus.start_pc;
            ir_d = '0;
        end else if (w_run && !w_halt) begin
            ipc_d = pc_q;
            if (w_take_br) begin
                // Discard the sequential word fetched this cycle.
                pc_d = w_br_target;
                ir_d = '0;
            end else begin
                pc_d = pc_q + 1'b1;
                ir_d = bus.rom_data;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            ipc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            ipc_q <= ipc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] cyc_q;
    logic [15:0] tkn_q;

    // Saturating run-cycle and taken-branch counters, cleared on program start
    always_ff @(posedge Clk) begin
        if (Reset || w_start) begin
            cyc_q <= '0;
            tkn_q <= '0;
        end else if (w_run) begin
            if (cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
            if (w_take_br && (tkn_q != 16'hFFFF)) tkn_q <= tkn_q + 16'd1;
        end
    end

    assign cycle_cnt = cyc_q;
    assign taken_cnt = tkn_q;
`endif

endmodule
`default_nettype wire
